// File: rtl/mem_responder.sv
// Bus-side word memory that answers one read/write request at a time.
// Tracks a per-word written bit so reads of unwritten words are flagged.
module mem_responder #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DEPTH-1:0]  written_q, written_d;
  logic              mem_we;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      written_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      written_q <= written_d;
    end
  end

  // Array contents survive reset; only the written bits are cleared.
  always_ff @(posedge Clock) begin
    if (!Resetn && mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    written_d = written_q;
    mem_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = wr;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          if (wr_q) begin
            mem_we            = 1'b1;
            written_d[addr_q] = 1'b1;
            err_d             = 1'b0;
          end else if (written_q[addr_q]) begin
            rdata_d = mem_q[addr_q];
            err_d   = 1'b0;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign ack   = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic,
// checked every cycle against a timestamp-based transaction model.
module tb_mem_responder;

  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic          Clock  = 1'b0;
  logic          Resetn = 1'b1;
  logic          req    = 1'b0;
  logic          wr     = 1'b0;
  logic [AW-1:0] addr   = '0;
  logic [DW-1:0] wdata  = '0;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          err;
  logic          busy;

  mem_responder #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .LATENCY(LAT)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .req   (req),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .err   (err),
    .busy  (busy)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Model: memory, written flags, and edge timestamps of the
  // transaction in flight (accept edge + LAT = access edge).
  logic [DW-1:0] mm [DEPTH];
  bit            mw [DEPTH];
  int            e         = 0;
  int            last_busy = -10;
  bit            mok       = 1'b0;
  bit            p_v       = 1'b0;
  int            p_due;
  bit            p_wr;
  logic [AW-1:0] p_a;
  logic [DW-1:0] p_d;
  bit            txn_err   = 1'b0;
  logic [DW-1:0] m_rdata   = '0;
  bit            m_ack, m_err, m_busy;

  always @(posedge Clock) begin
    if (Resetn) begin
      mok = 1'b1;
      for (int i = 0; i < DEPTH; i++) mw[i] = 1'b0;
      p_v       = 1'b0;
      last_busy = e - 1;
      m_rdata   = '0;
      txn_err   = 1'b0;
    end else begin
      if (p_v && e == p_due) begin
        p_v = 1'b0;
        if (p_wr) begin
          mm[p_a] = p_d;
          mw[p_a] = 1'b1;
          txn_err = 1'b0;
        end else if (mw[p_a]) begin
          m_rdata = mm[p_a];
          txn_err = 1'b0;
        end else begin
          m_rdata = '0;
          txn_err = 1'b1;
        end
      end
      if (req && e >= last_busy + 2) begin
        p_v       = 1'b1;
        p_due     = e + LAT;
        last_busy = e + LAT;
        p_wr      = wr;
        p_a       = addr;
        p_d       = wdata;
      end
    end
    m_ack  = (e == last_busy);
    m_busy = (e <= last_busy);
    m_err  = m_ack && txn_err;
    e++;
  end

  always @(negedge Clock) begin
    if (mok) begin
      chk("m_rdata", 32'(rdata), 32'(m_rdata));
      chk("m_ack", 32'(ack), 32'(m_ack));
      chk("m_err", 32'(err), 32'(m_err));
      chk("m_busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic txn(input bit w, input int a, input int d, input bit scr,
                     output logic [DW-1:0] rd, output logic er,
                     output int lat, output int nb);
    @(negedge Clock);
    req   = 1'b1;
    wr    = w;
    addr  = a[AW-1:0];
    wdata = d[DW-1:0];
    @(posedge Clock);
    #1 nb = int'(busy);
    @(negedge Clock);
    req = 1'b0;
    if (scr) begin
      wr    = 1'b1;
      addr  = 7'd9;
      wdata = 16'hFFFF;
    end
    lat = -1;
    rd  = 'x;
    er  = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clock);
      #1 nb += int'(busy);
      if (ack) begin
        lat = i;
        rd  = rdata;
        er  = err;
        break;
      end
    end
    @(posedge Clock);
    #1 nb += int'(busy);
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            lat, nb;

  task automatic lit(input string nm, input bit w, input int a, input int d,
                     input bit scr, input int exp_rd, input bit exp_er);
    txn(w, a, d, scr, rd, er, lat, nb);
    chk({nm, "_lat"}, 32'(lat), LAT);
    chk({nm, "_rdata"}, 32'(rd), 32'(exp_rd));
    chk({nm, "_err"}, 32'(er), 32'(exp_er));
  endtask

  initial begin
    int nacks, prev;
    bit ackseen;
    repeat (2) @(negedge Clock);
    Resetn = 1'b0;

    txn(1'b0, 5, 0, 1'b0, rd, er, lat, nb);
    chk("rd_unwr_lat", 32'(lat), 2);
    chk("rd_unwr_rdata", 32'(rd), 32'h0);
    chk("rd_unwr_err", 32'(er), 32'h1);
    chk("rd_unwr_busy_cycles", 32'(nb), 32'd3);

    lit("wr5", 1'b1, 5, 'h1234, 1'b0, 'h0000, 1'b0);
    lit("rd5", 1'b0, 5, 0, 1'b0, 'h1234, 1'b0);
    lit("wr127", 1'b1, 127, 'hBEEF, 1'b0, 'h1234, 1'b0);
    lit("wr0", 1'b1, 0, 'h0001, 1'b0, 'h1234, 1'b0);
    lit("rd127", 1'b0, 127, 0, 1'b0, 'hBEEF, 1'b0);
    lit("rd0", 1'b0, 0, 0, 1'b0, 'h0001, 1'b0);
    lit("rd1", 1'b0, 1, 0, 1'b0, 'h0000, 1'b1);
    lit("rd5_scr", 1'b0, 5, 0, 1'b1, 'h1234, 1'b0);
    lit("rd9", 1'b0, 9, 0, 1'b0, 'h0000, 1'b1);

    @(negedge Clock);
    req  = 1'b1;
    wr   = 1'b0;
    addr = 7'd5;
    nacks = 0;
    prev  = -1;
    for (int k = 0; k <= 16; k++) begin
      @(posedge Clock);
      #1;
      if (ack) begin
        nacks++;
        chk("stream_rdata", 32'(rdata), 32'h1234);
        if (prev >= 0) chk("stream_gap", 32'(k - prev), 32'd4);
        prev = k;
      end
    end
    @(negedge Clock);
    req = 1'b0;
    chk("stream_acks", 32'(nacks), 32'd4);
    repeat (6) @(negedge Clock);

    req   = 1'b1;
    wr    = 1'b1;
    addr  = 7'd7;
    wdata = 16'h5555;
    @(posedge Clock);
    @(negedge Clock);
    req    = 1'b0;
    Resetn = 1'b1;
    @(negedge Clock);
    Resetn  = 1'b0;
    ackseen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge Clock);
      #1 if (ack) ackseen = 1'b1;
    end
    chk("abort_no_ack", 32'(ackseen), 32'h0);
    lit("rd7_after_abort", 1'b0, 7, 0, 1'b0, 'h0000, 1'b1);
    lit("rd5_after_reset", 1'b0, 5, 0, 1'b0, 'h0000, 1'b1);

    for (int k = 0; k < 3000; k++) begin
      @(negedge Clock);
      Resetn = ($urandom % 64 == 0);
      req    = $urandom % 2;
      wr     = $urandom % 2;
      addr   = ($urandom % 2) ? AW'($urandom % 8) : AW'($urandom);
      wdata  = DW'($urandom);
    end
    @(negedge Clock);
    Resetn = 1'b0;
    req    = 1'b0;
    repeat (6) @(negedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's address/data bus; serves the requests that the PC and the address register initiate.
- Accepts one read or write request at a time through a req/ack handshake.
- Holds an internal word array and answers after a fixed, parameterised latency.
- Tracks a per-word "written" bit, so a read of a never-written word is flagged instead of returning garbage.

Parameters:
ADDR_W, 7, address width; the array holds 2**ADDR_W words
DATA_W, 16, word width; matches the processor bus
LATENCY, 2, rising edges from request acceptance to access; legal range 1..15

Ports:
Clock  in  1  system clock; all state updates on the rising edge
Resetn  in  1  reset; synchronous, active-high (1 = reset)
req  in  1  request valid; level signal, sampled only in IDLE
wr  in  1  1 = write, 0 = read; sampled with req
addr  in  ADDR_W  word address; sampled with req
wdata  in  DATA_W  write data; sampled with req
rdata  out  DATA_W  read data; updated only on read completion, held otherwise
ack  out  1  one-cycle completion pulse
err  out  1  valid only while ack=1; 1 = read of an unwritten word
busy  out  1  1 while in BUSY or RESP

Behaviour:
- Reset, synchronous, active-high. On any edge with Resetn=1:
  - state <= IDLE, counter <= 0.
  - rdata=0, ack=0, err=0, busy=0.
  - All written bits cleared.
  - Array contents not cleared, but unreachable until rewritten.
  - Reset has priority over all other inputs.
- FSM states: IDLE, BUSY, RESP.
- IDLE (busy=0, ack=0):
  - If req=1 at an edge, latch addr, wr and wdata into holding registers.
  - Load counter = LATENCY-1 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY (busy=1):
  - If counter != 0: decrement the counter.
  - If counter == 0, perform the access at this edge and go to RESP:
    - Write: mem[addr_h] <= wdata_h; written[addr_h] <= 1; err <= 0; rdata unchanged.
    - Read of a written word: rdata <= mem[addr_h]; err <= 0.
    - Read of an unwritten word: rdata <= 0; err <= 1.
- RESP (busy=1, ack=1 for exactly one cycle): unconditionally go to IDLE at the next edge; ack <= 0, err <= 0.
- Latency: if a request is accepted at edge N, ack is 1 from edge N+LATENCY to edge N+LATENCY+1.
- Input changes:
  - req, wr, addr and wdata are ignored in BUSY and RESP; changing them does not affect the pending transaction.
  - No queueing: a req held high through RESP is accepted as a new transaction in the IDLE cycle that follows.
  - The requester must drop req in the ack cycle if it wants only one access.
  - Minimum spacing between acks: LATENCY+2 cycles.
- Write then read of the same address in consecutive transactions returns the new data; no bypass is needed.
- Reset mid-operation (in BUSY or RESP):
  - Pending transaction is aborted; no array write and no written-bit update occur.
  - ack drops at that edge.
- Address wrap: addr is exactly ADDR_W bits wide, so there are no out-of-range addresses.
- Widths: counter is 4 bits; a LATENCY outside 1..15 is a configuration error, flagged by an elaboration check.

Test Plan:
- Reset, then read addr 5 -> ack at acceptance edge+2, err=1, rdata=0x0000, busy=1 for 3 cycles.
- Write 0x1234 to addr 5, then read addr 5 -> write ack err=0 with rdata still 0x0000; read ack err=0, rdata=0x1234.
- Write 0xBEEF to addr 127 and 0x0001 to addr 0, then read both -> 0xBEEF and 0x0001; addr 1 read gives err=1.
- Accept a read of addr 5; in BUSY change addr to 9 and wdata to 0xFFFF with wr=1 -> read of addr 5 completes, rdata=0x1234, no write to addr 9.
- Hold req=1 continuously, reading addr 5 -> one ack every 4 cycles (LATENCY=2), each with rdata=0x1234.
- Accept a write of 0x5555 to addr 7; pulse Resetn=1 during BUSY; then read addr 7 -> no ack for the aborted write; read gives err=1, rdata=0.
